lif_sequencer: RTL and testbench
================================

LIF_SEQUENCER -- requirements
Module: lif_sequencer

Interface
REQ-001 Parameter: THRESHOLD, 230, firing threshold applied to each stored 8-bit membrane potential.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 step  input  1  one-cycle pulse requesting one timestep sweep over neurons 0..3.
REQ-005 cur_idx  output  2  index of the neuron whose input current is being requested.
REQ-006 cur_data  input  8  input current for neuron cur_idx; sampled in FETCH.
REQ-007 busy  output  1  high from the cycle after an accepted step through DONE inclusive.
REQ-008 done  output  1  one-cycle pulse in DONE, when the sweep completes.
REQ-009 spk_valid  output  1  spike event valid.
REQ-010 spk_ready  input  1  spike event accepted by consumer.
REQ-011 spk_idx  output  2  index of the spiking neuron; valid while spk_valid is high.
REQ-012 overrun  output  1  sticky flag: a step arrived while busy.
REQ-013 state_sel  input  2  readout neuron select.
REQ-014 state_out  output  8  combinational stored potential of neuron state_sel.

Function
REQ-015 FSM states: IDLE, FETCH, UPDATE, EMIT, DONE; one state per cycle except EMIT.
REQ-016 IDLE: on step=1, set idx=0 and go to FETCH; otherwise stay in IDLE.
REQ-017 FETCH: cur_idx=idx; register cur_data; go to UPDATE.
REQ-018 UPDATE: fire = (pot[idx] >= THRESHOLD), evaluated on the stored pre-update potential.
REQ-019 UPDATE with fire=1: pot[idx] <= 0; go to EMIT.
REQ-020 UPDATE with fire=0: pot[idx] <= min(255, cur + (pot>>1) + (pot>>2) + (pot>>3)); sum computed at 10 bits, saturated to 8 bits; then advance.
REQ-021 EMIT: spk_valid=1, spk_idx=idx, both held stable until the cycle spk_valid and spk_ready are both high; advance on that cycle.
REQ-022 Advance: if idx==3 go to DONE, else idx+1 and go to FETCH.
REQ-023 DONE: done=1 for one cycle; return to IDLE.
REQ-024 With no spikes, done is asserted exactly 9 cycles after the cycle step is sampled; each spike adds one or more EMIT cycles.
REQ-025 step while busy: ignored, sweep unaffected, overrun set to 1 and held until rst.
REQ-026 step in the same cycle as DONE counts as busy (ignored, overrun set); step in IDLE is accepted.
REQ-027 cur_idx drives idx in every state; cur_data is ignored outside FETCH.

Reset
REQ-028 rst=1 forces IDLE, idx=0, pot[0..3]=0, busy=0, done=0, spk_valid=0, spk_idx=0, overrun=0, all refractory counters=0, on the next edge.
REQ-029 rst asserted mid-sweep (including during EMIT) aborts the sweep; no done pulse; a pending spike is dropped.

Configuration
REQ-030 Macro LIF_REFRACTORY_EN defined: each neuron has a 2-bit refractory counter, loaded with 2 when it fires.
REQ-031 With LIF_REFRACTORY_EN, UPDATE on a neuron with counter>0: pot stays 0, counter decrements, fire forced to 0, current ignored.
REQ-032 Without LIF_REFRACTORY_EN: no counters; a neuron integrates on the sweep immediately after firing.

Verification
REQ-033 rst; step; cur_data=0 -> done exactly 9 cycles after step; spk_valid never high; state_out=0 for all sel.
REQ-034 cur_data=200 constant; step x3 -> after step 1 pot=200; after step 2 pot=255 (375 saturated); during step 3 spk_idx 0,1,2,3 in order; afterwards pot=0.
REQ-035 Spike pending with spk_ready=0 for 5 cycles -> spk_valid=1 and spk_idx constant throughout; cur_idx frozen; done delayed by 5 cycles.
REQ-036 step issued 3 cycles into a sweep -> no second sweep; overrun=1, still 1 after two further sweeps; cleared by rst.
REQ-037 rst during EMIT of neuron 1 -> next cycle all outputs at reset values; next step starts at cur_idx=0.
REQ-038 LIF_REFRACTORY_EN, cur_data=200 -> after a neuron fires, pot stays 0 for 2 sweeps, then reaches 200 on the 3rd sweep; without the macro, pot=200 on the 1st sweep.

Source files
------------

// File: rtl/lif_sequencer.sv
// Four-neuron leaky integrate-and-fire sequencer: one step pulse sweeps neurons 0..3.
// Optional per-neuron refractory counters are enabled with `define LIF_REFRACTORY_EN.
module lif_sequencer #(
  parameter int unsigned THRESHOLD = 230
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       step,
  output logic [1:0] cur_idx,
  input  logic [7:0] cur_data,
  output logic       busy,
  output logic       done,
  output logic       spk_valid,
  input  logic       spk_ready,
  output logic [1:0] spk_idx,
  output logic       overrun,
  input  logic [1:0] state_sel,
  output logic [7:0] state_out
);

  localparam logic [7:0] THR = 8'(THRESHOLD);

  typedef enum logic [2:0] {IDLE, FETCH, UPDATE, EMIT, DONE} state_t;

  state_t     state;
  state_t     state_next;
  logic [1:0] idx;
  logic [7:0] pot [4];
  logic [7:0] cur_q;
  logic [7:0] pot_cur;
  logic [9:0] sum;
  logic [7:0] pot_next;
  logic       fire;
  logic       advance;
`ifdef LIF_REFRACTORY_EN
  logic [1:0] refr [4];
`endif

  // Leak keeps 7/8 of the stored potential; sum is 10 bits wide so saturation is exact.
  always_comb begin
    pot_cur  = pot[idx];
    sum      = {2'b00, cur_q} + {2'b00, pot_cur >> 1} + {2'b00, pot_cur >> 2}
             + {2'b00, pot_cur >> 3};
    pot_next = (sum > 10'd255) ? 8'hFF : sum[7:0];
`ifdef LIF_REFRACTORY_EN
    fire     = (pot_cur >= THR) && (refr[idx] == 2'd0);
`else
    fire     = (pot_cur >= THR);
`endif
    advance  = ((state == UPDATE) && !fire) || ((state == EMIT) && spk_ready);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:   if (step) state_next = FETCH;
      FETCH:  state_next = UPDATE;
      UPDATE: begin
        if (fire)              state_next = EMIT;
        else if (idx == 2'd3)  state_next = DONE;
        else                   state_next = FETCH;
      end
      EMIT: begin
        if (spk_ready) state_next = (idx == 2'd3) ? DONE : FETCH;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    done      = (state == DONE);
    spk_valid = (state == EMIT);
    cur_idx   = idx;
    spk_idx   = idx;
    state_out = pot[state_sel];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx     <= '0;
      cur_q   <= '0;
      overrun <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) begin
        pot[i] <= '0;
`ifdef LIF_REFRACTORY_EN
        refr[i] <= '0;
`endif
      end
    end else begin
      if (step && (state != IDLE)) overrun <= 1'b1;
      if ((state == IDLE) && step) idx <= '0;
      if (state == FETCH) cur_q <= cur_data;
      if (state == UPDATE) begin
`ifdef LIF_REFRACTORY_EN
        if (refr[idx] != 2'd0) begin
          refr[idx] <= refr[idx] - 2'd1;
          pot[idx]  <= '0;
        end else if (fire) begin
          refr[idx] <= 2'd2;
          pot[idx]  <= '0;
        end else begin
          pot[idx]  <= pot_next;
        end
`else
        pot[idx] <= fire ? 8'd0 : pot_next;
`endif
      end
      if (advance && (idx != 2'd3)) idx <= idx + 2'd1;
    end
  end

endmodule

// File: tb/tb_lif_sequencer.sv
// Directed self-checking bench for lif_sequencer; expectations follow LIF_REFRACTORY_EN if defined.
module tb_lif_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       step = 1'b0;
  logic [1:0] cur_idx;
  logic [7:0] cur_data = 8'd0;
  logic       busy;
  logic       done;
  logic       spk_valid;
  logic       spk_ready = 1'b1;
  logic [1:0] spk_idx;
  logic       overrun;
  logic [1:0] state_sel = 2'd0;
  logic [7:0] state_out;

  int checks = 0;
  int errors = 0;

  lif_sequencer #(.THRESHOLD(230)) dut (
    .clk(clk), .rst(rst), .step(step), .cur_idx(cur_idx), .cur_data(cur_data),
    .busy(busy), .done(done), .spk_valid(spk_valid), .spk_ready(spk_ready),
    .spk_idx(spk_idx), .overrun(overrun), .state_sel(state_sel), .state_out(state_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Pulses step, waits (bounded) for done, records accepted spikes, returns to IDLE.
  task automatic do_step(output int cycles, output int nspk, output logic [7:0] seq);
    step = 1'b1;
    tick();
    step = 1'b0;
    cycles = 1;
    nspk = 0;
    seq = '0;
    while (!done && cycles < 200) begin
      if (spk_valid && spk_ready && nspk < 4) begin
        seq[nspk*2 +: 2] = spk_idx;
        nspk++;
      end
      tick();
      cycles++;
    end
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (spk_valid !== 1'b0) begin errors++; $display("FAIL reset_spk_valid got %b want 0", spk_valid); end
    checks++; if (spk_idx !== 2'd0) begin errors++; $display("FAIL reset_spk_idx got %0d want 0", spk_idx); end
    checks++; if (cur_idx !== 2'd0) begin errors++; $display("FAIL reset_cur_idx got %0d want 0", cur_idx); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", overrun); end
    for (int s = 0; s < 4; s++) begin
      state_sel = 2'(s);
      #1;
      checks++;
      if (state_out !== 8'd0) begin errors++; $display("FAIL reset_pot%0d got %0d want 0", s, state_out); end
    end
    rst = 1'b0;
  endtask

  task automatic test_no_spike();
    int cyc;
    int seen_spk;
    do_reset();
    cur_data = 8'd0;
    seen_spk = 0;
    step = 1'b1;
    tick();
    step = 1'b0;
    cyc = 1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL nospk_busy got %b want 1", busy); end
    while (!done && cyc < 200) begin
      if (spk_valid) seen_spk++;
      tick();
      cyc++;
    end
    checks++; if (cyc !== 9) begin errors++; $display("FAIL nospk_latency got %0d want 9", cyc); end
    checks++; if (seen_spk !== 0) begin errors++; $display("FAIL nospk_spk_valid got %0d want 0", seen_spk); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL nospk_busy_done got %b want 1", busy); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL nospk_done_pulse got %b want 0", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL nospk_idle got %b want 0", busy); end
    for (int s = 0; s < 4; s++) begin
      state_sel = 2'(s);
      #1;
      checks++;
      if (state_out !== 8'd0) begin errors++; $display("FAIL nospk_pot%0d got %0d want 0", s, state_out); end
    end
  endtask

  task automatic test_saturate();
    int cyc;
    int nspk;
    logic [7:0] seq;
    logic [7:0] exp_pot [3];
    int exp_cyc [3];
    int exp_nspk [3];
    exp_pot = '{8'd200, 8'd255, 8'd0};
    exp_cyc = '{9, 9, 13};
    exp_nspk = '{0, 0, 4};
    do_reset();
    cur_data = 8'd200;
    for (int k = 0; k < 3; k++) begin
      do_step(cyc, nspk, seq);
      checks++; if (cyc !== exp_cyc[k]) begin errors++; $display("FAIL sat_latency%0d got %0d want %0d", k, cyc, exp_cyc[k]); end
      checks++; if (nspk !== exp_nspk[k]) begin errors++; $display("FAIL sat_nspk%0d got %0d want %0d", k, nspk, exp_nspk[k]); end
      for (int s = 0; s < 4; s++) begin
        state_sel = 2'(s);
        #1;
        checks++;
        if (state_out !== exp_pot[k]) begin errors++; $display("FAIL sat_pot%0d_s%0d got %0d want %0d", s, k, state_out, exp_pot[k]); end
      end
    end
    checks++; if (seq !== 8'hE4) begin errors++; $display("FAIL sat_spike_order got %h want e4", seq); end
  endtask

  task automatic test_threshold_edge();
    int cyc;
    int nspk;
    logic [7:0] seq;
    do_reset();
    cur_data = 8'd229;
    do_step(cyc, nspk, seq);
    cur_data = 8'd0;
    do_step(cyc, nspk, seq);
    state_sel = 2'd2;
    #1;
    checks++; if (nspk !== 0) begin errors++; $display("FAIL thr229_nspk got %0d want 0", nspk); end
    checks++; if (state_out !== 8'd199) begin errors++; $display("FAIL thr229_leak got %0d want 199", state_out); end
    do_reset();
    cur_data = 8'd230;
    do_step(cyc, nspk, seq);
    cur_data = 8'd0;
    do_step(cyc, nspk, seq);
    #1;
    checks++; if (nspk !== 4) begin errors++; $display("FAIL thr230_nspk got %0d want 4", nspk); end
    checks++; if (state_out !== 8'd0) begin errors++; $display("FAIL thr230_pot got %0d want 0", state_out); end
  endtask

  task automatic test_backpressure();
    int cyc;
    int nspk;
    logic [7:0] seq;
    do_reset();
    cur_data = 8'd200;
    do_step(cyc, nspk, seq);
    do_step(cyc, nspk, seq);
    spk_ready = 1'b0;
    step = 1'b1;
    tick();
    step = 1'b0;
    tick();
    tick();
    cyc = 3;
    for (int k = 0; k < 6; k++) begin
      checks++; if (spk_valid !== 1'b1) begin errors++; $display("FAIL bp_valid%0d got %b want 1", k, spk_valid); end
      checks++; if (spk_idx !== 2'd0) begin errors++; $display("FAIL bp_idx%0d got %0d want 0", k, spk_idx); end
      checks++; if (cur_idx !== 2'd0) begin errors++; $display("FAIL bp_cur_idx%0d got %0d want 0", k, cur_idx); end
      if (k == 5) spk_ready = 1'b1;
      tick();
      cyc++;
    end
    while (!done && cyc < 200) begin
      tick();
      cyc++;
    end
    checks++; if (cyc !== 18) begin errors++; $display("FAIL bp_latency got %0d want 18", cyc); end
    tick();
  endtask

  task automatic test_overrun();
    int cyc;
    int nspk;
    logic [7:0] seq;
    do_reset();
    cur_data = 8'd0;
    step = 1'b1;
    tick();
    step = 1'b0;
    cyc = 1;
    while (!done && cyc < 200) begin
      step = (cyc == 3);
      tick();
      cyc++;
    end
    step = 1'b0;
    checks++; if (cyc !== 9) begin errors++; $display("FAIL ovr_latency got %0d want 9", cyc); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag got %b want 1", overrun); end
    tick();
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ovr_no_second_sweep got %b want 0", busy); end
    for (int k = 0; k < 2; k++) begin
      do_step(cyc, nspk, seq);
      checks++; if (cyc !== 9) begin errors++; $display("FAIL ovr_sweep%0d_latency got %0d want 9", k, cyc); end
      checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky%0d got %b want 1", k, overrun); end
    end
    do_reset();
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_cleared got %b want 0", overrun); end
    step = 1'b1;
    tick();
    step = 1'b0;
    cyc = 1;
    while (!done && cyc < 200) begin
      tick();
      cyc++;
    end
    step = 1'b1;
    tick();
    step = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ovr_done_step_busy got %b want 0", busy); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_done_step_flag got %b want 1", overrun); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ovr_done_step_idle got %b want 0", busy); end
  endtask

  task automatic test_reset_emit();
    int cyc;
    int nspk;
    int seen_done;
    logic [7:0] seq;
    do_reset();
    cur_data = 8'd200;
    do_step(cyc, nspk, seq);
    do_step(cyc, nspk, seq);
    step = 1'b1;
    tick();
    step = 1'b0;
    cyc = 1;
    while (!(spk_valid && spk_idx == 2'd1) && cyc < 50) begin
      tick();
      cyc++;
    end
    checks++; if (cyc !== 6) begin errors++; $display("FAIL rste_reach_emit1 got %0d want 6", cyc); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rste_busy got %b want 0", busy); end
    checks++; if (spk_valid !== 1'b0) begin errors++; $display("FAIL rste_spk_valid got %b want 0", spk_valid); end
    checks++; if (spk_idx !== 2'd0) begin errors++; $display("FAIL rste_spk_idx got %0d want 0", spk_idx); end
    checks++; if (cur_idx !== 2'd0) begin errors++; $display("FAIL rste_cur_idx got %0d want 0", cur_idx); end
    for (int s = 0; s < 4; s++) begin
      state_sel = 2'(s);
      #1;
      checks++;
      if (state_out !== 8'd0) begin errors++; $display("FAIL rste_pot%0d got %0d want 0", s, state_out); end
    end
    seen_done = 0;
    for (int k = 0; k < 12; k++) begin
      if (done) seen_done++;
      tick();
    end
    checks++; if (seen_done !== 0) begin errors++; $display("FAIL rste_no_done got %0d want 0", seen_done); end
    cur_data = 8'd0;
    step = 1'b1;
    tick();
    step = 1'b0;
    checks++; if (cur_idx !== 2'd0) begin errors++; $display("FAIL rste_restart_idx got %0d want 0", cur_idx); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rste_restart_busy got %b want 1", busy); end
    cyc = 1;
    while (!done && cyc < 200) begin
      tick();
      cyc++;
    end
    checks++; if (cyc !== 9) begin errors++; $display("FAIL rste_restart_latency got %0d want 9", cyc); end
    tick();
  endtask

  task automatic test_refractory();
    int cyc;
    int nspk;
    logic [7:0] seq;
    logic [7:0] exp_pot [3];
    int exp_nspk [3];
`ifdef LIF_REFRACTORY_EN
    exp_pot = '{8'd0, 8'd0, 8'd200};
    exp_nspk = '{0, 0, 0};
`else
    exp_pot = '{8'd200, 8'd255, 8'd0};
    exp_nspk = '{0, 0, 4};
`endif
    do_reset();
    cur_data = 8'd200;
    for (int k = 0; k < 3; k++) do_step(cyc, nspk, seq);
    state_sel = 2'd0;
    for (int k = 0; k < 3; k++) begin
      do_step(cyc, nspk, seq);
      #1;
      checks++; if (state_out !== exp_pot[k]) begin errors++; $display("FAIL refr_pot_sweep%0d got %0d want %0d", k, state_out, exp_pot[k]); end
      checks++; if (nspk !== exp_nspk[k]) begin errors++; $display("FAIL refr_nspk_sweep%0d got %0d want %0d", k, nspk, exp_nspk[k]); end
    end
  endtask

  initial begin
    test_reset();
    test_no_spike();
    test_saturate();
    test_threshold_edge();
    test_backpressure();
    test_overrun();
    test_reset_emit();
    test_refractory();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
